// File: rtl/block_transfer_ctrl.sv
// LDM/STM block transfer sequencer: walks a register list one memory beat per
// accepted req/ready handshake, then optionally writes back the updated base.
module block_transfer_ctrl #(
  parameter int WORD_SIZE  = 32,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_load,
  input  logic                  up,
  input  logic                  pre,
  input  logic                  writeback,
  input  logic [ADDR_WIDTH-1:0] base_idx,
  input  logic [WORD_SIZE-1:0]  base_val,
  input  logic [NUM_REGS-1:0]   reg_list,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [WORD_SIZE-1:0]  mem_addr,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  input  logic                  mem_ready,
  input  logic [WORD_SIZE-1:0]  mem_rdata,
  output logic [ADDR_WIDTH-1:0] rf_read_addr,
  input  logic [WORD_SIZE-1:0]  rf_read_data,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [WORD_SIZE-1:0]  rf_wdata,
  output logic                  pc_we,
  output logic [WORD_SIZE-1:0]  pc_wdata,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(NUM_REGS + 1);
  localparam logic [ADDR_WIDTH-1:0] PC_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, WB = 2'd2} state_t;

  state_t                state_q;
  logic                  is_load_q;
  logic                  wb_q;
  logic [ADDR_WIDTH-1:0] base_idx_q;
  logic [WORD_SIZE-1:0]  final_base_q;
  logic [NUM_REGS-1:0]   list_q;
  logic [WORD_SIZE-1:0]  addr_q;

  logic [CW-1:0]         n_s;
  logic [WORD_SIZE-1:0]  span_s;
  logic [WORD_SIZE-1:0]  start_addr_s;
  logic [ADDR_WIDTH-1:0] cur_s;
  logic [NUM_REGS-1:0]   list_d;
  logic                  xfer_s;
  logic                  load_acc_s;

  // Popcount of the incoming list and the derived start address.
  always_comb begin
    n_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      n_s = n_s + CW'(reg_list[i]);
    end
    span_s = WORD_SIZE'(n_s) << 2;
    case ({up, pre})
      2'b10:   start_addr_s = base_val;
      2'b11:   start_addr_s = base_val + WORD_SIZE'(4);
      2'b00:   start_addr_s = base_val - span_s + WORD_SIZE'(4);
      2'b01:   start_addr_s = base_val - span_s;
      default: start_addr_s = base_val;
    endcase
  end

  // Lowest remaining register; clearing the lowest set bit gives the next list.
  always_comb begin
    cur_s = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (list_q[i]) begin
        cur_s = ADDR_WIDTH'(i);
      end else begin
        cur_s = cur_s;
      end
    end
    list_d = list_q & (list_q - NUM_REGS'(1));
  end

  // Sequencer state and latched transfer fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      is_load_q    <= 1'b0;
      wb_q         <= 1'b0;
      base_idx_q   <= '0;
      final_base_q <= '0;
      list_q       <= '0;
      addr_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            is_load_q    <= is_load;
            base_idx_q   <= base_idx;
            final_base_q <= up ? (base_val + span_s) : (base_val - span_s);
            list_q       <= reg_list;
            addr_q       <= start_addr_s;
            // A load that reloads the base keeps the loaded value.
            wb_q         <= writeback && (n_s != '0) && !(is_load && reg_list[base_idx]);
            state_q      <= (n_s == '0) ? WB : XFER;
          end
        end
        XFER: begin
          if (mem_ready) begin
            list_q <= list_d;
            addr_q <= addr_q + WORD_SIZE'(4);
            if (list_d == '0) begin
              state_q <= WB;
            end
          end
        end
        WB:      state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign xfer_s     = (state_q == XFER);
  assign load_acc_s = xfer_s && is_load_q && mem_ready;

  // Output decode from state; load writes fire in the accepting cycle.
  always_comb begin
    mem_req       = xfer_s;
    mem_we        = xfer_s && !is_load_q;
    mem_addr      = xfer_s ? addr_q : '0;
    rf_read_addr  = (xfer_s && !is_load_q) ? cur_s : '0;
    mem_wdata     = (xfer_s && !is_load_q) ? rf_read_data : '0;
    busy          = (state_q != IDLE);
    done          = (state_q == WB);
    rf_we         = 1'b0;
    rf_write_addr = '0;
    rf_wdata      = '0;
    pc_we         = 1'b0;
    pc_wdata      = '0;
    if (load_acc_s && (cur_s == PC_IDX)) begin
      pc_we    = 1'b1;
      pc_wdata = mem_rdata;
    end else if (load_acc_s) begin
      rf_we         = 1'b1;
      rf_write_addr = cur_s;
      rf_wdata      = mem_rdata;
    end else if ((state_q == WB) && wb_q) begin
      rf_we         = 1'b1;
      rf_write_addr = base_idx_q;
      rf_wdata      = final_base_q;
    end else begin
      rf_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_block_transfer_ctrl.sv
// Scoreboard bench for block_transfer_ctrl: expected beats are queued at start
// and popped as the DUT presents them.
module tb_block_transfer_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, is_load, up, pre, writeback;
  logic [3:0]  base_idx;
  logic [31:0] base_val;
  logic [15:0] reg_list;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  rf_read_addr, rf_write_addr;
  logic [31:0] rf_read_data, rf_wdata, pc_wdata;
  logic        rf_we, pc_we, busy, done;

  logic [31:0] rf [16];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  idx;
    logic [31:0] rdata;
  } beat_t;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  assign rf_read_data = rf[rf_read_addr];
  assign mem_rdata    = mem_addr ^ 32'hC3C3_5A5A;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'h1000_0000 + i;
    end else if (rf_we) begin
      rf[rf_write_addr] <= rf_wdata;
    end
  end

  block_transfer_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load), .up(up), .pre(pre),
    .writeback(writeback), .base_idx(base_idx), .base_val(base_val), .reg_list(reg_list),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .rf_read_addr(rf_read_addr),
    .rf_read_data(rf_read_data), .rf_we(rf_we), .rf_write_addr(rf_write_addr),
    .rf_wdata(rf_wdata), .pc_we(pc_we), .pc_wdata(pc_wdata), .busy(busy), .done(done)
  );

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; is_load = 1'b0; up = 1'b0; pre = 1'b0; writeback = 1'b0;
    base_idx = 4'd0; base_val = 32'd0; reg_list = 16'd0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, rf_we, pc_we, busy, done} !== 6'b0 || mem_addr !== 32'd0 ||
        rf_wdata !== 32'd0 || pc_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b we=%b rf_we=%b pc_we=%b busy=%b done=%b addr=%h expected all 0",
               mem_req, mem_we, rf_we, pc_we, busy, done, mem_addr);
    end
  endtask

  // Runs one full transfer; stall holds mem_ready low for that many cycles on the first beat.
  task automatic run_xfer(input logic ld, input logic u, input logic p, input logic w,
                          input logic [3:0] bidx, input logic [31:0] base,
                          input logic [15:0] list, input int stall, input logic poke,
                          input string tag);
    beat_t b;
    int n, cyc, sc;
    bit fin;
    logic [31:0] a, fb;
    logic ewb;
    n = 0;
    for (int i = 0; i < 16; i++) if (list[i]) n++;
    a = u ? base + (p ? 32'd4 : 32'd0) : base - 32'(4 * n) + (p ? 32'd0 : 32'd4);
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        b.addr = a; b.we = !ld; b.wdata = rf[i]; b.idx = 4'(i); b.rdata = a ^ 32'hC3C3_5A5A;
        exp_q.push_back(b);
        a = a + 32'd4;
      end
    end
    fb  = u ? base + 32'(4 * n) : base - 32'(4 * n);
    ewb = w && (n != 0) && !(ld && list[bidx]);

    @(negedge clk);
    start = 1'b1; is_load = ld; up = u; pre = p; writeback = w;
    base_idx = bidx; base_val = base; reg_list = list; mem_ready = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || rf_we !== 1'b0 || pc_we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s start_cycle: req=%b rf_we=%b pc_we=%b busy=%b expected 0", tag, mem_req, rf_we, pc_we, busy);
    end
    cyc = 0; sc = stall; fin = 0;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start     = poke && (cyc == 2);
      reg_list  = (poke && cyc == 2) ? 16'hFFFF : list;
      is_load   = (poke && cyc == 2) ? !ld : ld;
      mem_ready = (sc == 0);
      #1;
      if (mem_req) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_beat: addr=%h with no beat expected", tag, mem_addr);
        end else begin
          b = exp_q[0];
          if (mem_addr !== b.addr || mem_we !== b.we || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s beat: addr=%h we=%b busy=%b done=%b expected addr=%h we=%b busy=1 done=0",
                     tag, mem_addr, mem_we, busy, done, b.addr, b.we);
          end
          if (!ld) begin
            checks++;
            if (rf_read_addr !== b.idx || mem_wdata !== b.wdata) begin
              errors++;
              $display("FAIL %s store_data: raddr=%0d wdata=%h expected raddr=%0d wdata=%h",
                       tag, rf_read_addr, mem_wdata, b.idx, b.wdata);
            end
          end
          checks++;
          if (mem_ready && ld && b.idx == 4'd15) begin
            if (pc_we !== 1'b1 || pc_wdata !== b.rdata || rf_we !== 1'b0) begin
              errors++;
              $display("FAIL %s pc_load: pc_we=%b pc_wdata=%h rf_we=%b expected pc_we=1 pc_wdata=%h rf_we=0",
                       tag, pc_we, pc_wdata, rf_we, b.rdata);
            end
          end else if (mem_ready && ld) begin
            if (rf_we !== 1'b1 || rf_write_addr !== b.idx || rf_wdata !== b.rdata || pc_we !== 1'b0) begin
              errors++;
              $display("FAIL %s rf_load: rf_we=%b waddr=%0d wdata=%h pc_we=%b expected 1/%0d/%h/0",
                       tag, rf_we, rf_write_addr, rf_wdata, pc_we, b.idx, b.rdata);
            end
          end else if (rf_we !== 1'b0 || pc_we !== 1'b0) begin
            errors++;
            $display("FAIL %s no_write: rf_we=%b pc_we=%b expected 0 0 (ready=%b)", tag, rf_we, pc_we, mem_ready);
          end
          if (mem_ready) void'(exp_q.pop_front());
          else sc--;
        end
      end else begin
        fin = 1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || exp_q.size() != 0 || cyc != n + 1 + stall || pc_we !== 1'b0) begin
          errors++;
          $display("FAIL %s wb_cycle: done=%b busy=%b left=%0d cycle=%0d pc_we=%b expected done=1 busy=1 left=0 cycle=%0d pc_we=0",
                   tag, done, busy, exp_q.size(), cyc, pc_we, n + 1 + stall);
        end
        checks++;
        if (rf_we !== ewb || (ewb && (rf_write_addr !== bidx || rf_wdata !== fb))) begin
          errors++;
          $display("FAIL %s base_wb: rf_we=%b waddr=%0d wdata=%h expected rf_we=%b waddr=%0d wdata=%h",
                   tag, rf_we, rf_write_addr, rf_wdata, ewb, bidx, fb);
        end
      end
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL %s timeout: no completion within 200 cycles", tag);
    end
    @(negedge clk);
    start = 1'b0; mem_ready = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL %s back_to_idle: busy=%b done=%b req=%b rf_we=%b expected 0", tag, busy, done, mem_req, rf_we);
    end
  endtask

  task automatic test_stm_up_post();
    run_xfer(1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 32'h0000_0100, 16'h000E, 0, 1'b0, "stm_up_post");
  endtask

  task automatic test_ldm_down_pre_pc();
    run_xfer(1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 32'h0000_0200, 16'h8001, 0, 1'b0, "ldm_down_pre_pc");
  endtask

  task automatic test_stall();
    run_xfer(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0000_0400, 16'h0010, 3, 1'b0, "stall");
  endtask

  task automatic test_empty_and_base_in_list();
    run_xfer(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 32'h0000_0700, 16'h0000, 0, 1'b0, "empty_list");
    run_xfer(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 32'h0000_0500, 16'h0006, 0, 1'b0, "ldm_base_in_list");
    run_xfer(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 32'h0000_0600, 16'h0003, 0, 1'b0, "stm_base_in_list");
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    start = 1'b1; is_load = 1'b1; up = 1'b1; pre = 1'b0; writeback = 1'b1;
    base_idx = 4'd1; base_val = 32'h0000_0300; reg_list = 16'h000F; mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0300) begin
      errors++;
      $display("FAIL abort_first_beat: req=%b addr=%h expected req=1 addr=00000300", mem_req, mem_addr);
    end
    @(negedge clk);
    mem_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, rf_we, pc_we, busy, done} !== 6'b0 || mem_addr !== 32'd0) begin
      errors++;
      $display("FAIL abort_outputs: req=%b we=%b rf_we=%b pc_we=%b busy=%b done=%b addr=%h expected all 0",
               mem_req, mem_we, rf_we, pc_we, busy, done, mem_addr);
    end
    run_xfer(1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 32'h0000_0800, 16'h00FF, 0, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    run_xfer(1'b0, 1'b1, 1'b1, 1'b1, 4'd8, 32'h0000_0900, 16'h0C30, 0, 1'b1, "start_while_busy");
    run_xfer(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 32'hFFFF_FFFC, 16'h0003, 0, 1'b0, "wrap");
  endtask

  initial begin
    test_reset();
    test_stm_up_post();
    test_ldm_down_pre_pc();
    test_stall();
    test_empty_and_base_in_list();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
